// File: rtl/ram_d_arbiter.sv
// rtl/ram_d_arbiter.sv - two-port arbiter in front of the single-port data RAM
// Issues one registered RAM command per cycle and returns read data two cycles after grant.
module ram_d_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 328,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef struct packed {
        logic valid;
        logic port;
        logic is_read;
        logic err;
    } tag_t;

    logic              prio1_q, prio1_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    tag_t              tag0_q, tag0_d;
    tag_t              tag1_q, tag1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    // prio1_q set means port 1 wins the next contested cycle
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                if (FIXED_PRIO != 0 || !prio1_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        any_gnt   = gnt0 | gnt1;
        sel_we    = gnt1 ? we1 : we0;
        sel_addr  = gnt1 ? addr1 : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
        in_range  = sel_addr < DEPTH_A;

        prio1_d   = prio1_q;
        address_d = address_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        if (any_gnt) begin
            prio1_d = gnt0;
            if (in_range) begin
                address_d = sel_addr;
                data_d    = sel_wdata;
                wren_d    = sel_we;
            end
        end

        tag0_d.valid   = any_gnt;
        tag0_d.port    = gnt1;
        tag0_d.is_read = !sel_we;
        tag0_d.err     = !in_range;
        tag1_d         = tag0_q;
    end

    // q is already aligned with the second tag stage, so read data passes straight through
    always_comb begin
        rvalid0  = tag1_q.valid && tag1_q.is_read && !tag1_q.err && !tag1_q.port;
        rvalid1  = tag1_q.valid && tag1_q.is_read && !tag1_q.err && tag1_q.port;
        err0     = tag1_q.valid && tag1_q.err && !tag1_q.port;
        err1     = tag1_q.valid && tag1_q.err && tag1_q.port;
        rdata0_d = rvalid0 ? q : rdata0_q;
        rdata1_d = rvalid1 ? q : rdata1_q;
        rdata0   = rdata0_d;
        rdata1   = rdata1_d;
        address  = address_q;
        data     = data_q;
        wren     = wren_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio1_q   <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            tag0_q    <= '0;
            tag1_q    <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            prio1_q   <= prio1_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            tag0_q    <= tag0_d;
            tag1_q    <= tag1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_ram_d_arbiter.sv
// tb/tb_ram_d_arbiter.sv - self-checking bench for ram_d_arbiter
// Reference model tracks memory, grants and return events; directed vectors pin it with literals.
module tb_ram_d_arbiter;

    localparam int DEPTH = 328;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, wren;
    logic [31:0] rdata0, rdata1, address, data;
    logic [31:0] q;

    logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_err0, f_err1, f_wren;
    logic [31:0] f_rdata0, f_rdata1, f_address, f_data;
    logic [31:0] f_q = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_d_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .FIXED_PRIO(0)) dut (
        .clock(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .address(address), .data(data), .wren(wren), .q(q)
    );

    ram_d_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .FIXED_PRIO(1)) dut_fixed (
        .clock(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rvalid0), .rvalid1(f_rvalid1),
        .rdata0(f_rdata0), .rdata1(f_rdata1), .err0(f_err0), .err1(f_err1),
        .address(f_address), .data(f_data), .wren(f_wren), .q(f_q)
    );

    // RAM device: initial contents are 0x3C + address, so word 5 holds 0x41
    logic [31:0] ram_wr [int];
    always @(posedge clk) begin
        if (address < 32'(DEPTH)) begin
            q <= ram_wr.exists(int'(address)) ? ram_wr[int'(address)] : 32'h3C + address;
            if (wren) ram_wr[int'(address)] = data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [31:0] mmem [int];
    function automatic logic [31:0] mget(input logic [31:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : 32'h3C + a;
    endfunction

    int          cyc = 0;
    int          last_port = 1;
    logic        ev_v [4], ev_port [4], ev_read [4], ev_err [4];
    logic [31:0] ev_data [4];
    logic        e_wren = 1'b0;
    logic [31:0] e_addr = '0, e_data = '0;
    logic [31:0] e_rdata [2] = '{32'h0, 32'h0};

    initial for (int i = 0; i < 4; i++) ev_v[i] = 1'b0;

    always @(negedge clk) begin
        int   s, ns, p;
        logic g0, g1, bv, bw;
        logic [31:0] ba, bd;
        cyc++;
        s = cyc % 4;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                if (last_port == 1) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
        chk("gnt0", 32'(gnt0), 32'(g0));
        chk("gnt1", 32'(gnt1), 32'(g1));
        chk("fixed_gnt0", 32'(f_gnt0), 32'(!reset && req0));
        chk("fixed_gnt1", 32'(f_gnt1), 32'(!reset && req1 && !req0));
        if (!reset) begin
            bv = ev_v[s] && ev_read[s] && !ev_err[s];
            chk("rvalid0", 32'(rvalid0), 32'(bv && !ev_port[s]));
            chk("rvalid1", 32'(rvalid1), 32'(bv && ev_port[s]));
            chk("err0", 32'(err0), 32'(ev_v[s] && ev_err[s] && !ev_port[s]));
            chk("err1", 32'(err1), 32'(ev_v[s] && ev_err[s] && ev_port[s]));
            if (bv) e_rdata[ev_port[s] ? 1 : 0] = ev_data[s];
            chk("rdata0", rdata0, e_rdata[0]);
            chk("rdata1", rdata1, e_rdata[1]);
            chk("wren", 32'(wren), 32'(e_wren));
            chk("address", address, e_addr);
            chk("data", data, e_data);
        end
        ev_v[s] = 1'b0;
        if (reset) begin
            for (int i = 0; i < 4; i++) ev_v[i] = 1'b0;
            e_wren = 1'b0;
            e_addr = '0;
            e_data = '0;
            e_rdata[0] = '0;
            e_rdata[1] = '0;
            last_port = 1;
        end else begin
            e_wren = 1'b0;
            if (g0 || g1) begin
                p  = g1 ? 1 : 0;
                bw = g1 ? we1 : we0;
                ba = g1 ? addr1 : addr0;
                bd = g1 ? wdata1 : wdata0;
                ns = (cyc + 2) % 4;
                ev_v[ns]    = 1'b1;
                ev_port[ns] = (p == 1);
                ev_read[ns] = !bw;
                ev_err[ns]  = (ba >= 32'(DEPTH));
                ev_data[ns] = (!bw && ba < 32'(DEPTH)) ? mget(ba) : 32'h0;
                if (ba < 32'(DEPTH)) begin
                    e_wren = bw;
                    e_addr = ba;
                    e_data = bd;
                    if (bw) mmem[int'(ba)] = bd;
                end
                last_port = p;
            end
        end
    end

    // One request from port p, held until granted; returns at the start of the next cycle
    task automatic port_op(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic got;
        int   n;
        got = 1'b0;
        n = 0;
        if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        while (!got && n < 20) begin
            @(negedge clk);
            got = (p == 0) ? gnt0 : gnt1;
            n++;
        end
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: port %0d got no grant within %0d cycles", p, n);
        end
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    logic [5:0] gs, fs;
    int         rv_cnt;

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_wren", 32'(wren), 32'h0);
        chk("reset_address", address, 32'h0);
        chk("reset_rdata0", rdata0, 32'h0);
        @(posedge clk); #1;

        port_op(0, 1'b0, 32'd5, 32'h0);
        @(negedge clk);
        chk("lit_rd5_address", address, 32'd5);
        chk("lit_rd5_wren", 32'(wren), 32'h0);
        @(negedge clk);
        chk("lit_rd5_rvalid0", 32'(rvalid0), 32'h1);
        chk("lit_rd5_rdata0", rdata0, 32'h0000_0041);
        @(posedge clk); #1;

        port_op(1, 1'b1, 32'd10, 32'hDEAD_BEEF);
        port_op(1, 1'b0, 32'd10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("lit_raw_rvalid1", 32'(rvalid1), 32'h1);
        chk("lit_raw_rdata1", rdata1, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd7;
        gs = '0;
        fs = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gs = {gs[4:0], gnt0};
            fs = {fs[4:0], f_gnt0};
            @(posedge clk); #1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("lit_rr_seq", 32'(gs), 32'b101010);
        chk("lit_fixed_seq", 32'(fs), 32'b111111);
        idle(3);

        port_op(0, 1'b0, 32'd328, 32'h0);
        @(negedge clk);
        chk("lit_oor_wren", 32'(wren), 32'h0);
        @(negedge clk);
        chk("lit_oor_err0", 32'(err0), 32'h1);
        chk("lit_oor_rvalid0", 32'(rvalid0), 32'h0);
        @(posedge clk); #1;
        port_op(1, 1'b1, 32'd400, 32'h1234_5678);
        port_op(0, 1'b0, 32'd327, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("lit_rd327_rdata0", rdata0, 32'h0000_0183);
        @(posedge clk); #1;

        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        @(negedge clk);
        chk("lit_inflight_gnt0", 32'(gnt0), 32'h1);
        @(posedge clk); #1;
        req0 = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("lit_post_reset_rvalid0", 32'(rvalid0), 32'h0);
        chk("lit_post_reset_err0", 32'(err0), 32'h0);
        chk("lit_post_reset_rdata0", rdata0, 32'h0);
        chk("lit_post_reset_address", address, 32'h0);
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rv_cnt += int'(rvalid0) + int'(err0);
        end
        chk("lit_inflight_dropped", 32'(rv_cnt), 32'h0);
        @(posedge clk); #1;

        port_op(0, 1'b0, 32'd1, 32'h0);
        idle(5);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd2;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        @(negedge clk);
        chk("lit_idle_ptr_gnt1", 32'(gnt1), 32'h1);
        chk("lit_idle_ptr_gnt0", 32'(gnt0), 32'h0);
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
